behaviour_sqrt: RTL and testbench
=================================

# behaviour_sqrt

Sequential integer square-root unit. It repeatedly samples an unsigned operand, computes its floor square root over a fixed number of clock cycles, and presents the result on a registered output. An enable input freezes the whole engine, output included. It is a standalone arithmetic leaf block, used wherever a slow, low-area square root of a byte-wide value is enough.

## Interface
- DATA_W, default 8: operand width. Must be even. The root occupies DATA_W/2 bits.
- clk_i, input, 1: single clock; all logic is on the rising edge.
- rstn_i, input, 1: reset. Synchronous and active-high despite the suffix: rstn_i = 1 at a rising edge resets the block.
- enb_i, input, 1: enable. 1 = engine runs; 0 = all state and dt_o hold.
- dt_i, input, DATA_W: unsigned operand. Sampled only in state LOAD.
- dt_o, output, DATA_W: floor(sqrt(operand)), zero-extended, registered.

## Operation
- Result: dt_o = largest r with r*r <= x, where x is the captured operand. For DATA_W=8, r is in 0..15 and dt_o[7:4] is always 0.
- Registers:
  - x_q: captured operand, DATA_W bits.
  - root_q: DATA_W/2 bits.
  - it_q: iteration index, DATA_W/2 - 1 down to 0.
  - state_q.
  - dt_o.
- State machine, free-running while enb_i=1:
  - LOAD: x_q <= dt_i; root_q <= 0; it_q <= DATA_W/2-1; go to CALC.
  - CALC: compute trial = root_q | (1 << it_q). If trial*trial <= x_q, root_q <= trial. Compare unsigned at DATA_W bits; the product cannot overflow. If it_q == 0, go to DONE; otherwise decrement it_q.
  - DONE: dt_o <= {zeros, root_q}; go to LOAD.
- The engine restarts automatically, so dt_o tracks dt_i continuously.
- enb_i = 0: no register changes, including state_q, it_q, x_q and dt_o. When enb_i returns to 1, execution resumes at the frozen state with the previously captured x_q. A dt_i change while disabled has no effect until the next LOAD after re-enable.
- Reset (rstn_i=1) has priority over enb_i and applies mid-computation:
  - dt_o = 0, root_q = 0, x_q = 0, it_q = 0.
  - state_q = LOAD.
- Boundaries: x=0 gives 0. x=1, 2, 3 give 1. Perfect squares are exact (e.g. 225 gives 15). x=255 gives 15. There is no error or overflow condition.

## Timing
- The iteration period is 2 + DATA_W/2 cycles: LOAD, DATA_W/2 CALC cycles, then DONE. For DATA_W=8 this is 6 cycles.
- Latency, with enb_i=1 and dt_i held stable:
  - A new dt_i is reflected on dt_o at most 2*(2 + DATA_W/2) cycles after it changes: 12 cycles for DATA_W=8.
  - Exactly 6 cycles after dt_i is sampled in LOAD.
- dt_i must be stable at the rising edge where state is LOAD. Changes in other cycles are ignored.
- After reset is released, the first LOAD is the first enabled edge. The first valid dt_o appears 6 edges later; dt_o reads 0 until then.
- dt_o changes only on the DONE edge, or on reset.

## Structure
- Package sqrt_pkg:
  - typedef enum logic [1:0] {LOAD, CALC, DONE} state_t.
  - Constants DATA_W=8 (default), ROOT_W=DATA_W/2, ITER=ROOT_W.
- Optional combinational sub-module sqrt_step: inputs root, it, x; output next root. It holds the trial and compare logic. The top holds the FSM and registers.

## Test plan
- Reset: hold rstn_i=1 for 2 cycles with dt_i=200 -> dt_o=0 and state LOAD. Release reset; dt_o stays 0 for the first 5 edges, then reads 14.
- Exhaustive sweep: dt_i = 0..255, each held 15 cycles with enb_i=1. At the end of each hold, dt_o = floor sqrt. Spot checks:
  - 0→0, 1→1, 3→1, 4→2.
  - 15→3, 16→4, 99→9, 100→10.
  - 224→14, 225→15, 255→15.
- Enable hold: settle dt_i=100 (dt_o=10), then drop enb_i and drive dt_i=101..., 15 cycles each -> dt_o stays 10. Repeat with dt_i=255 (dt_o=15) followed by dt_i=0 while disabled -> dt_o stays 15.
- Mid-computation freeze: drop enb_i while in CALC, change dt_i, hold 20 cycles, then re-enable -> the result reflects the old captured operand first, then the new operand on the next period.
- Latency: with enb_i=1, change dt_i from 0 to 144 at a LOAD edge -> dt_o=12 exactly 6 edges later. Change it one cycle after LOAD -> dt_o=12 within 12 edges.
- Reset mid-operation: assert rstn_i during CALC with dt_o=15 -> dt_o=0 on that edge, and the computation restarts from LOAD.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sequential integer square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DONE
  } state_t;

  localparam int DATA_W = 8;
  localparam int ROOT_W = DATA_W / 2;
  localparam int ITER   = ROOT_W;

  // Width of the iteration index; never narrower than one bit.
  function automatic int it_width(input int root_w);
    return (root_w > 1) ? $clog2(root_w) : 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root step: try setting bit 'it' of the partial root
// and keep it when the trial squared still fits under the operand.
module sqrt_step #(
  parameter int DATA_W = 8,
  parameter int IT_W   = 2
) (
  input  logic [DATA_W/2-1:0] root,
  input  logic [IT_W-1:0]     it,
  input  logic [DATA_W-1:0]   x,
  output logic [DATA_W/2-1:0] root_nxt
);

  localparam int RW = DATA_W / 2;

  logic [RW-1:0]     trial;
  logic [DATA_W-1:0] trial_w;
  logic [DATA_W-1:0] trial_sq;

  // A RW-bit value squared always fits in DATA_W bits, so no overflow here.
  always_comb begin
    trial    = root | (RW'(1) << it);
    trial_w  = DATA_W'(trial);
    trial_sq = trial_w * trial_w;
    root_nxt = (trial_sq <= x) ? trial : root;
  end

endmodule

// File: rtl/behaviour_sqrt.sv
// Sequential floor square root: LOAD, DATA_W/2 CALC steps, DONE, then restart.
// enb_i freezes every register; rstn_i is a synchronous active-high reset.
module behaviour_sqrt #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enb_i,
  input  logic [DATA_W-1:0] dt_i,
  output logic [DATA_W-1:0] dt_o
);

  import sqrt_pkg::*;

  localparam int RW = DATA_W / 2;
  localparam int IW = it_width(RW);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [RW-1:0]     root_q, root_d;
  logic [IW-1:0]     it_q, it_d;
  logic [DATA_W-1:0] dt_q, dt_d;
  logic [RW-1:0]     root_nxt;

  sqrt_step #(
    .DATA_W (DATA_W),
    .IT_W   (IW)
  ) u_step (
    .root     (root_q),
    .it       (it_q),
    .x        (x_q),
    .root_nxt (root_nxt)
  );

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    root_d  = root_q;
    it_d    = it_q;
    dt_d    = dt_q;
    if (enb_i) begin
      unique case (state_q)
        LOAD: begin
          x_d     = dt_i;
          root_d  = '0;
          it_d    = IW'(RW - 1);
          state_d = CALC;
        end
        CALC: begin
          root_d = root_nxt;
          if (it_q == '0) state_d = DONE;
          else            it_d    = it_q - IW'(1);
        end
        DONE: begin
          dt_d    = DATA_W'(root_q);
          state_d = LOAD;
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values together.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q <= LOAD;
      x_q     <= '0;
      root_q  <= '0;
      it_q    <= '0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      root_q  <= root_d;
      it_q    <= it_d;
      dt_q    <= dt_d;
    end
  end

  assign dt_o = dt_q;

endmodule

// File: tb/tb_behaviour_sqrt.sv
// Self-checking bench for behaviour_sqrt: directed scenarios plus random
// stimulus, compared against a period-level reference model every cycle.
module tb_behaviour_sqrt;

  import sqrt_pkg::*;

  localparam int W      = 8;
  localparam int PERIOD = 2 + W / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enb = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: enabled edges since reset, captured operand, expected output.
  int unsigned  en_cnt = 0;
  logic [W-1:0] cap    = '0;
  logic [W-1:0] exp_q  = '0;

  behaviour_sqrt #(.DATA_W(W)) dut (
    .clk_i  (clk),
    .rstn_i (rst),
    .enb_i  (enb),
    .dt_i   (din),
    .dt_o   (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    int r = 0;
    for (int c = 0; c * c <= int'(x); c++) r = c;
    return W'(r);
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      en_cnt = 0;
      exp_q  = '0;
    end else if (enb) begin
      if (en_cnt % PERIOD == 0)          cap   = din;
      if (en_cnt % PERIOD == PERIOD - 1) exp_q = isqrt(cap);
      en_cnt++;
    end
    #1;
    check("model", 32'(dout), 32'(exp_q));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Run enabled until the next edge is period phase ph (0 = LOAD edge).
  task automatic align(input int ph);
    int guard = 0;
    enb = 1'b1;
    while (en_cnt % PERIOD != ph && guard < PERIOD) begin
      tick();
      guard++;
    end
    check("align", 32'(en_cnt % PERIOD), 32'(ph));
  endtask

  initial begin
    bit found;

    // Reset with an operand present
    rst = 1'b1; enb = 1'b1; din = 8'd200;
    hold(2);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(LOAD));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_zero", 32'(dout), 32'd0);
    end
    tick();
    check("post_rst_first", 32'(dout), 32'd14);

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      din = W'(v);
      hold(15);
      check("sweep", 32'(dout), 32'(isqrt(W'(v))));
      if (v == 0)   check("spot_0",   32'(dout), 32'd0);
      if (v == 3)   check("spot_3",   32'(dout), 32'd1);
      if (v == 16)  check("spot_16",  32'(dout), 32'd4);
      if (v == 99)  check("spot_99",  32'(dout), 32'd9);
      if (v == 100) check("spot_100", 32'(dout), 32'd10);
      if (v == 224) check("spot_224", 32'(dout), 32'd14);
      if (v == 225) check("spot_225", 32'(dout), 32'd15);
      if (v == 255) check("spot_255", 32'(dout), 32'd15);
    end

    // Enable hold
    din = 8'd100; hold(15);
    check("en_settle_100", 32'(dout), 32'd10);
    enb = 1'b0;
    for (int v = 101; v < 106; v++) begin
      din = W'(v); hold(15);
      check("en_hold_10", 32'(dout), 32'd10);
    end
    enb = 1'b1; din = 8'd255; hold(15);
    check("en_settle_255", 32'(dout), 32'd15);
    enb = 1'b0; din = 8'd0; hold(15);
    check("en_hold_15", 32'(dout), 32'd15);
    enb = 1'b1; hold(15);
    check("en_resume_0", 32'(dout), 32'd0);

    // Mid-computation freeze: 49 captured, 200 presented while frozen
    din = 8'd16; hold(15);
    align(0);
    din = 8'd49; tick();
    tick();
    din = 8'd200; enb = 1'b0;
    hold(20);
    check("freeze_hold", 32'(dout), 32'd4);
    enb = 1'b1;
    hold(4);
    check("freeze_old", 32'(dout), 32'd7);
    hold(6);
    check("freeze_new", 32'(dout), 32'd14);

    // Latency: change exactly at a LOAD edge
    din = 8'd0; hold(15);
    align(0);
    din = 8'd144;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lat_exact_pre", 32'(dout), 32'd0);
    end
    tick();
    check("lat_exact", 32'(dout), 32'd12);

    // Latency: change one cycle after LOAD
    din = 8'd0; hold(15);
    align(1);
    din = 8'd144;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dout == 8'd12) found = 1'b1;
    end
    check("lat_late_found", 32'(found), 32'd1);

    // Reset in the middle of CALC
    din = 8'd255; hold(15);
    align(2);
    rst = 1'b1; tick();
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(LOAD));
    rst = 1'b0;
    hold(5);
    check("midrst_wait", 32'(dout), 32'd0);
    tick();
    check("midrst_result", 32'(dout), 32'd15);

    // Random operands, enables and hold lengths
    for (int k = 0; k < 60; k++) begin
      din = W'($urandom_range(0, 255));
      enb = ($urandom_range(0, 3) != 0);
      hold($urandom_range(1, 9));
    end
    enb = 1'b1; din = W'($urandom_range(0, 255)); hold(15);
    check("rand_settle", 32'(dout), 32'(isqrt(din)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
